// File: rtl/addsub_accum_seq.sv
// Multi-operand accumulate sequencer driving an external 8-bit adder/subtractor.
// Streams operands over valid/ready and reports the final sum, a sticky overflow flag and the first overflow index.
module addsub_accum_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [7:0]       init_val,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_data,
  input  logic             op_sub,
  output logic [7:0]       as_a,
  output logic [7:0]       as_b,
  output logic             as_mode,
  input  logic [7:0]       as_result,
  input  logic             as_ovfl,
  output logic             busy,
  output logic             done,
  output logic [7:0]       acc_out,
  output logic             ovfl_sticky,
  output logic [CNT_W-1:0] ovfl_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num_ops_q;
  logic             handshake;
  logic             last_op;

  assign handshake = op_valid && (state == RUN);
  assign last_op   = (cnt == CNT_W'(num_ops_q - 1'b1));

  // NOTE: every register here uses <= so all updates see pre-edge values; the
  // synchronous rst branch comes first so it dominates start and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      num_ops_q   <= '0;
      ovfl_sticky <= 1'b0;
      ovfl_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc         <= init_val;
            cnt         <= '0;
            num_ops_q   <= num_ops;
            ovfl_sticky <= 1'b0;
            ovfl_idx    <= '0;
            state       <= (num_ops == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            acc <= as_result;
            cnt <= cnt + 1'b1;
            // Only the first overflow in a sequence records its index.
            if (as_ovfl && !ovfl_sticky) begin
              ovfl_sticky <= 1'b1;
              ovfl_idx    <= cnt;
            end
            if (last_op) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode the state register only, so there is
  // no combinational path from any input to op_ready.
  assign op_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign acc_out  = acc;

  assign as_a    = acc;
  assign as_b    = (state == RUN) ? op_data : 8'h00;
  assign as_mode = (state == RUN) && op_sub;

endmodule

// File: doc/addsub_accum_seq.md
# addsub_accum_seq

Multi-operand accumulate sequencer wrapped around the 8-bit combinational adder/subtractor. It accepts a stream of 8-bit operands over a valid/ready handshake, each tagged add or subtract. It drives the adder/subtractor with the running accumulator and the current operand, and registers the result and overflow flag back each cycle. On completion it reports the final two's-complement sum, a sticky overflow flag, and the index of the first overflowing operand.

## Interface
- CNT_W, 4: width of operand count and index; max sequence length 2^CNT_W−1.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  CNT_W/1  pulse (1 bit); begins a sequence, honoured only in IDLE.
- num_ops  in  CNT_W  operand count for the sequence, sampled with start.
- init_val  in  8  initial accumulator value, sampled with start.
- op_valid  in  1  operand available.
- op_ready  out  1  sequencer accepts operand this cycle.
- op_data  in  8  operand (two's complement).
- op_sub  in  1  0 = add, 1 = subtract for this operand.
- as_a  out  8  to adder/subtractor operand a (accumulator).
- as_b  out  8  to adder/subtractor operand b.
- as_mode  out  1  to adder/subtractor mode.
- as_result  in  8  from adder/subtractor result.
- as_ovfl  in  1  from adder/subtractor overflow.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- acc_out  out  8  accumulator register, valid and stable when done/IDLE.
- ovfl_sticky  out  1  any operand in the sequence overflowed.
- ovfl_idx  out  CNT_W  zero-based index of first overflowing operand; 0 if none.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: op_ready=0. On start=1: acc←init_val, cnt←0, ovfl_sticky←0, ovfl_idx←0, latch num_ops. If num_ops=0 → DONE, else → RUN.
- RUN: op_ready=1, busy=1. as_a=acc, as_b=op_data, as_mode=op_sub. On op_valid&op_ready (handshake): acc←as_result; if as_ovfl and ovfl_sticky=0, set ovfl_sticky←1, ovfl_idx←cnt; cnt←cnt+1. If cnt = num_ops−1 at handshake → DONE.
- No handshake in RUN: all state holds; no timeout.
- DONE: done=1 for exactly one cycle, op_ready=0, → IDLE unconditionally.
- Outside RUN: as_a=acc, as_b=0, as_mode=0.
- Arithmetic: 8-bit two's-complement wrap, no saturation; overflow is taken solely from as_ovfl. Later overflows never change ovfl_idx.
- start outside IDLE (RUN or DONE) ignored; num_ops/init_val changes after start ignored.
- acc_out, ovfl_sticky, ovfl_idx hold after DONE until next accepted start.

## Timing
- Reset values: state=IDLE, acc_out=0, op_ready=0, busy=0, done=0, ovfl_sticky=0, ovfl_idx=0, cnt=0, as_a=0, as_b=0, as_mode=0.
- rst dominates all other inputs; rst asserted mid-sequence aborts it with no done pulse.
- op_ready, busy, as_b, as_mode are functions of state (and op_data/op_sub combinationally); no input-to-op_ready path.
- Throughput: one operand per cycle in RUN.
- Latency: start edge → RUN next cycle; last handshake at edge N → done high in cycle N+1, acc_out final in same cycle; IDLE at N+2.
- num_ops=0: start at edge N → done in cycle N+1, acc_out=init_val.
- Earliest restart: start accepted in first IDLE cycle after DONE.

## Test plan
- Reset: drive rst 3 cycles mid-RUN → all outputs at reset values, no done, op_ready=0 next cycle.
- Add chain: init_val=0x05, num_ops=3, ops +0x10,+0x20,+0x01 back-to-back → done 1 cycle after 3rd handshake, acc_out=0x36, ovfl_sticky=0.
- Subtract + stalls: init_val=0x10, num_ops=2, ops −0x05 then +0x02, op_valid low 4 cycles between → acc_out=0x0D, done once, state held during stall.
- Overflow sticky: init_val=0x64, num_ops=3, ops +0x32 (→0x96, ovfl), +0x7F (→0x15), +0x01 → acc_out=0x16, ovfl_sticky=1, ovfl_idx=0.
- Zero-length: num_ops=0, init_val=0xA5 → done in cycle after start, op_ready never high, acc_out=0xA5.
- Ignored start: pulse start with different init_val during RUN and during DONE → sequence result unchanged, exactly one done per accepted start.
